// File: rtl/conv_pixel_packer.sv
// Packs a PIX_W pixel stream into PACK-lane words and buffers them in a small
// first-word-fall-through FIFO with ready/valid output. A word commits when its
// last lane fills or when the frame's final pixel arrives (then possibly partial,
// with keep marking written lanes and last set). Words that meet a full FIFO with
// no simultaneous pop are dropped and raise a sticky overflow flag.
module conv_pixel_packer #(
  parameter int unsigned PIX_W      = 8,
  parameter int unsigned PACK       = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned FRAME_PIX  = 196
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_px,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PIX_W*PACK-1:0] out_data,
  output logic [PACK-1:0]       out_keep,
  output logic                  out_last,
  output logic                  frame_done,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int unsigned OutW  = PIX_W * PACK;
  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned FrmW  = (FRAME_PIX > 1) ? $clog2(FRAME_PIX) : 1;
  localparam int unsigned PtrW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW  = PtrW + 1;

  // Assembly state
  logic [OutW-1:0]  asm_q, asm_d;
  logic [LaneW-1:0] lane_q, lane_d;
  logic [FrmW-1:0]  frm_q, frm_d;

  // FIFO state
  logic [OutW-1:0] mem_data_q [FIFO_DEPTH];
  logic [PACK-1:0] mem_keep_q [FIFO_DEPTH];
  logic            mem_last_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic frame_done_q, frame_done_d;
  logic overflow_q, overflow_d;

  logic [OutW-1:0] merged;
  logic [PACK-1:0] keep_c;
  logic            frame_end;
  logic            commit;
  logic            full;
  logic            pop;
  logic            push;
  logic            drop;

  // Merge the incoming pixel into the assembly word and decide whether it commits.
  always_comb begin
    merged                          = asm_q;
    merged[lane_q*PIX_W +: PIX_W]   = in_px;
    for (int k = 0; k < PACK; k++) begin
      keep_c[k] = (LaneW'(k) <= lane_q);
    end
    frame_end = (frm_q == FrmW'(FRAME_PIX - 1));
    commit    = in_valid && ((lane_q == LaneW'(PACK - 1)) || frame_end);
  end

  // FIFO handshake: a pop frees the slot the concurrent push needs, so full+pop never drops.
  always_comb begin
    full = (cnt_q == CntW'(FIFO_DEPTH));
    pop  = out_valid && out_ready;
    push = commit && (!full || pop);
    drop = commit && full && !pop;
  end

  // Next-state for lane/frame counters, assembly word, pointers and flags.
  always_comb begin
    asm_d        = asm_q;
    lane_d       = lane_q;
    frm_d        = frm_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    frame_done_d = commit && frame_end;
    overflow_d   = overflow_q;

    if (in_valid) begin
      if (commit) begin
        // Clearing here keeps unwritten lanes of a partial word at zero.
        asm_d  = '0;
        lane_d = '0;
      end else begin
        asm_d  = merged;
        lane_d = lane_q + LaneW'(1);
      end
      frm_d = frame_end ? '0 : frm_q + FrmW'(1);
    end

    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push && !pop)      cnt_d = cnt_q + CntW'(1);
    else if (pop && !push) cnt_d = cnt_q - CntW'(1);

    if (drop)              overflow_d = 1'b1;
    else if (clr_overflow) overflow_d = 1'b0;
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q        <= '0;
      lane_q       <= '0;
      frm_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      lane_q       <= lane_d;
      frm_q        <= frm_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  // FIFO storage; contents are don't-care until written, outputs are gated when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= merged;
      mem_keep_q[wr_ptr_q] <= keep_c;
      mem_last_q[wr_ptr_q] <= frame_end;
    end
  end

  // Head-of-FIFO outputs, forced to zero when empty.
  always_comb begin
    out_valid  = (cnt_q != '0);
    out_data   = out_valid ? mem_data_q[rd_ptr_q] : '0;
    out_keep   = out_valid ? mem_keep_q[rd_ptr_q] : '0;
    out_last   = out_valid ? mem_last_q[rd_ptr_q] : 1'b0;
    frame_done = frame_done_q;
    overflow   = overflow_q;
  end

endmodule

// File: tb/tb_conv_pixel_packer.sv
// Directed bench for conv_pixel_packer. Two instances share stimulus: u_dut_a has an
// 8-pixel frame (whole words only), u_dut_b a 6-pixel frame (partial final word).
module tb_conv_pixel_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_px = '0;
  logic        out_ready = 1'b0;
  logic        clr_overflow = 1'b0;

  logic        a_valid, a_last, a_fd, a_ovf;
  logic [31:0] a_data;
  logic [3:0]  a_keep;
  logic        b_valid, b_last, b_fd, b_ovf;
  logic [31:0] b_data;
  logic [3:0]  b_keep;

  int n_checks = 0;
  int n_errors = 0;
  int fda = 0;
  int fdb = 0;
  logic [36:0] qa [$];
  logic [36:0] qb [$];

  always #5 clk = ~clk;

  conv_pixel_packer #(.PIX_W(8), .PACK(4), .FIFO_DEPTH(8), .FRAME_PIX(8)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_px(in_px),
    .out_valid(a_valid), .out_ready(out_ready), .out_data(a_data), .out_keep(a_keep),
    .out_last(a_last), .frame_done(a_fd), .overflow(a_ovf), .clr_overflow(clr_overflow)
  );

  conv_pixel_packer #(.PIX_W(8), .PACK(4), .FIFO_DEPTH(8), .FRAME_PIX(6)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_px(in_px),
    .out_valid(b_valid), .out_ready(out_ready), .out_data(b_data), .out_keep(b_keep),
    .out_last(b_last), .frame_done(b_fd), .overflow(b_ovf), .clr_overflow(clr_overflow)
  );

  // Record every accepted word and every frame_done pulse.
  always @(posedge clk) begin
    if (!rst && a_valid && out_ready) qa.push_back({a_last, a_keep, a_data});
    if (!rst && b_valid && out_ready) qb.push_back({b_last, b_keep, b_data});
    if (a_fd) fda++;
    if (b_fd) fdb++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag, input bit use_b, input int idx,
                             input logic [31:0] d, input logic [3:0] k, input logic l);
    logic [36:0] w;
    w = 'x;
    if (use_b) begin
      if (idx < qb.size()) w = qb[idx];
    end else begin
      if (idx < qa.size()) w = qa[idx];
    end
    check({tag, "_data"}, 64'(w[31:0]), 64'(d));
    check({tag, "_keep"}, 64'(w[35:32]), 64'(k));
    check({tag, "_last"}, 64'(w[36]), 64'(l));
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_px(input logic [7:0] v);
    in_valid = 1'b1;
    in_px    = v;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    in_valid     = 1'b0;
    clr_overflow = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  function automatic logic [31:0] seq_word(input int k);
    return {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
  endfunction

  initial begin
    int base;
    int fd0;

    @(negedge clk);
    do_reset();
    check("rst_valid", 64'(a_valid), 64'd0);
    check("rst_ovf", 64'(a_ovf), 64'd0);

    // Two full words per 8-pixel frame, ready held high.
    out_ready = 1'b1;
    base = qa.size();
    fd0  = fda;
    for (int i = 1; i <= 3; i++) push_px(8'(i));
    check("t1_no_word_yet", 64'(a_valid), 64'd0);
    push_px(8'h04);
    check("t1_latency", 64'(a_valid), 64'd1);
    for (int i = 5; i <= 8; i++) push_px(8'(i));
    idle(3);
    check("t1_count", 64'(qa.size() - base), 64'd2);
    expect_word("t1_w0", 1'b0, base,     32'h04030201, 4'hF, 1'b0);
    expect_word("t1_w1", 1'b0, base + 1, 32'h08070605, 4'hF, 1'b1);
    check("t1_frame_done", 64'(fda - fd0), 64'd1);
    check("t1_ovf", 64'(a_ovf), 64'd0);

    // 6-pixel frame: partial final word, next frame restarts at lane 0.
    do_reset();
    base = qb.size();
    fd0  = fdb;
    for (int i = 0; i < 6; i++) push_px(8'(8'h10 + i));
    for (int i = 0; i < 4; i++) push_px(8'(8'h20 + i));
    idle(3);
    check("t2_count", 64'(qb.size() - base), 64'd3);
    expect_word("t2_w0", 1'b1, base,     32'h13121110, 4'hF, 1'b0);
    expect_word("t2_w1", 1'b1, base + 1, 32'h00001514, 4'b0011, 1'b1);
    expect_word("t2_w2", 1'b1, base + 2, 32'h23222120, 4'hF, 1'b0);
    check("t2_frame_done", 64'(fdb - fd0), 64'd1);

    // Overflow: no pops, 9 words offered to an 8-deep FIFO.
    do_reset();
    out_ready = 1'b0;
    fd0 = fda;
    for (int i = 0; i < 36; i++) push_px(8'(i));
    check("t3_ovf_set", 64'(a_ovf), 64'd1);
    check("t3_head", 64'(a_data), 64'h03020100);
    idle(2);
    check("t3_head_stable", 64'(a_data), 64'h03020100);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("t3_ovf_clr", 64'(a_ovf), 64'd0);
    // Drop and clear on the same edge: set must win.
    for (int i = 36; i < 39; i++) push_px(8'(i));
    clr_overflow = 1'b1;
    push_px(8'd39);
    clr_overflow = 1'b0;
    check("t3_set_wins", 64'(a_ovf), 64'd1);
    clr_overflow = 1'b1;
    idle(1);
    clr_overflow = 1'b0;
    check("t3_ovf_clr2", 64'(a_ovf), 64'd0);
    idle(2);
    check("t3_frame_done", 64'(fda - fd0), 64'd5);
    base = qa.size();
    out_ready = 1'b1;
    idle(10);
    out_ready = 1'b0;
    check("t3_drain_count", 64'(qa.size() - base), 64'd8);
    for (int k = 0; k < 8; k++) begin
      expect_word($sformatf("t3_w%0d", k), 1'b0, base + k, seq_word(k), 4'hF, 1'((k % 2) == 1));
    end

    // Full FIFO with push and pop on the same edge: nothing dropped.
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 35; i++) push_px(8'(i));
    check("t4_ovf_full", 64'(a_ovf), 64'd0);
    base = qa.size();
    out_ready = 1'b1;
    push_px(8'd35);
    out_ready = 1'b0;
    check("t4_ovf_pushpop", 64'(a_ovf), 64'd0);
    check("t4_pop_count", 64'(qa.size() - base), 64'd1);
    expect_word("t4_pop", 1'b0, base, 32'h03020100, 4'hF, 1'b0);
    base = qa.size();
    out_ready = 1'b1;
    idle(10);
    out_ready = 1'b0;
    check("t4_drain_count", 64'(qa.size() - base), 64'd8);
    for (int k = 1; k <= 8; k++) begin
      expect_word($sformatf("t4_w%0d", k), 1'b0, base + k - 1, seq_word(k), 4'hF,
                  1'((k % 2) == 1));
    end
    check("t4_empty", 64'(a_valid), 64'd0);

    // Reset with a buffered word and a partial word pending.
    for (int i = 0; i < 6; i++) push_px(8'(8'h50 + i));
    check("t5_pre_valid", 64'(a_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid", 64'(a_valid), 64'd0);
    check("t5_rst_data", 64'(a_data), 64'd0);
    check("t5_rst_keep", 64'(a_keep), 64'd0);
    check("t5_rst_last", 64'(a_last), 64'd0);
    check("t5_rst_fd", 64'(a_fd), 64'd0);
    idle(2);
    check("t5_rst_valid_hold", 64'(a_valid), 64'd0);
    rst = 1'b0;
    idle(1);
    out_ready = 1'b1;
    base = qa.size();
    for (int i = 0; i < 8; i++) push_px(8'(8'hA0 + i));
    idle(3);
    check("t5_count", 64'(qa.size() - base), 64'd2);
    expect_word("t5_w0", 1'b0, base,     32'hA3A2A1A0, 4'hF, 1'b0);
    expect_word("t5_w1", 1'b0, base + 1, 32'hA7A6A5A4, 4'hF, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
